// File: rtl/mem_arbiter_if.sv
// Request, RAM and response signals between the fetch/LSU requesters, the arbiter and the shared RAM.
// The arbiter connects through the slave modport; the surrounding core and RAM use the master modport.
interface mem_arbiter_if #(
  parameter int unsigned Width     = 32,
  parameter int unsigned AddrWidth = 8
);
  localparam int unsigned MaskW = Width / 8;

  // Instruction fetch port (read only)
  logic                 instr_valid_i;
  logic                 instr_ready_o;
  logic [AddrWidth-1:0] instr_addr_i;
  logic [Width-1:0]     instr_rd_data_o;
  logic                 instr_rd_valid_o;

  // Load/store port
  logic                 data_valid_i;
  logic                 data_ready_o;
  logic [AddrWidth-1:0] data_addr_i;
  logic [Width-1:0]     data_wr_data_i;
  logic [MaskW-1:0]     data_wmask_i;
  logic [Width-1:0]     data_rd_data_o;
  logic                 data_rd_valid_o;

  // Shared single-port RAM
  logic                 mem_valid_o;
  logic                 mem_ready_i;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [Width-1:0]     mem_wr_data_o;
  logic [MaskW-1:0]     mem_wmask_o;
  logic [Width-1:0]     mem_rd_data_i;
  logic                 mem_rd_valid_i;

  modport slave (
    input  instr_valid_i, instr_addr_i,
    output instr_ready_o, instr_rd_data_o, instr_rd_valid_o,
    input  data_valid_i, data_addr_i, data_wr_data_i, data_wmask_i,
    output data_ready_o, data_rd_data_o, data_rd_valid_o,
    output mem_valid_o, mem_addr_o, mem_wr_data_o, mem_wmask_o,
    input  mem_ready_i, mem_rd_data_i, mem_rd_valid_i
  );

  modport master (
    output instr_valid_i, instr_addr_i,
    input  instr_ready_o, instr_rd_data_o, instr_rd_valid_o,
    output data_valid_i, data_addr_i, data_wr_data_i, data_wmask_i,
    input  data_ready_o, data_rd_data_o, data_rd_valid_o,
    input  mem_valid_o, mem_addr_o, mem_wr_data_o, mem_wmask_o,
    output mem_ready_i, mem_rd_data_i, mem_rd_valid_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one 1rw RAM between instruction fetch and load/store.
// An in-order owner FIFO steers each RAM response back to the port that issued it.
module mem_arbiter #(
  parameter int unsigned Width          = 32,
  parameter int unsigned AddrWidth      = 8,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned MaskW = Width / 8;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

  localparam logic OwnerInstr = 1'b0;
  localparam logic OwnerData  = 1'b1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [Width-1:0]     wr_data;
    logic [MaskW-1:0]     wmask;
  } mem_req_t;

  logic [CntW-1:0]           count_q, count_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                      prio_q, prio_d;
  logic [MaxOutstanding-1:0] owner_q, owner_d;

  logic     any_valid;
  logic     grant_data;
  logic     grant_instr;
  logic     pop;
  logic     can_issue;
  logic     accept;
  logic     head_owner;
  logic     resp_live;
  mem_req_t req;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return ptr + PtrW'(1);
  endfunction

  // Grant and capacity; a response popping this cycle frees its slot immediately
  always_comb begin
    any_valid   = bus.instr_valid_i || bus.data_valid_i;
    grant_data  = bus.data_valid_i && (!bus.instr_valid_i || (prio_q == OwnerData));
    grant_instr = bus.instr_valid_i && !grant_data;
    pop         = bus.mem_rd_valid_i && (count_q != '0);
    can_issue   = !rst_i && bus.mem_ready_i &&
                  ((count_q < CntW'(MaxOutstanding)) || pop);
    accept      = any_valid && can_issue;
    head_owner  = owner_q[rd_ptr_q];
    resp_live   = !rst_i && pop;
  end

  // Winner's payload; fetches never write
  always_comb begin
    req = '0;
    if (!rst_i) begin
      if (grant_data) begin
        req.addr    = bus.data_addr_i;
        req.wr_data = bus.data_wr_data_i;
        req.wmask   = bus.data_wmask_i;
      end else if (grant_instr) begin
        req.addr = bus.instr_addr_i;
      end
    end
  end

  always_comb begin
    bus.instr_ready_o = grant_instr && can_issue;
    bus.data_ready_o  = grant_data && can_issue;
    bus.mem_valid_o   = accept;
    bus.mem_addr_o    = req.addr;
    bus.mem_wr_data_o = req.wr_data;
    bus.mem_wmask_o   = req.wmask;
  end

  // Response steering from the FIFO head; orphans fall through with no pulse
  always_comb begin
    bus.instr_rd_valid_o = 1'b0;
    bus.instr_rd_data_o  = '0;
    bus.data_rd_valid_o  = 1'b0;
    bus.data_rd_data_o   = '0;
    if (resp_live) begin
      if (head_owner == OwnerData) begin
        bus.data_rd_valid_o = 1'b1;
        bus.data_rd_data_o  = bus.mem_rd_data_i;
      end else begin
        bus.instr_rd_valid_o = 1'b1;
        bus.instr_rd_data_o  = bus.mem_rd_data_i;
      end
    end
  end

  // Owner FIFO, occupancy and round-robin pointer next state
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    owner_d  = owner_q;

    if (accept) begin
      owner_d[wr_ptr_q] = grant_data ? OwnerData : OwnerInstr;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      prio_d            = grant_data ? OwnerInstr : OwnerData;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      prio_q   <= OwnerData;
      owner_q  <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single-cycle behaviour plus hand sequences
// for backpressure, reset with requests in flight and idle priority hold, against a RAM stub.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic lat3;
  logic flush;

  int tests_run;
  int tests_failed;

  mem_arbiter_if #(.Width(32), .AddrWidth(8)) bus ();

  mem_arbiter #(.Width(32), .AddrWidth(8), .MaxOutstanding(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stub: 1 or 3 cycle response latency; writes return 0 as their ack data
  logic [31:0] ram [64];
  logic [2:0]  rv_pipe;
  logic [31:0] rd_pipe [3];
  logic        acc;

  assign acc = bus.mem_valid_o && bus.mem_ready_i;

  always @(posedge clk) begin
    if (flush) rv_pipe <= '0;
    else       rv_pipe <= {rv_pipe[1:0], acc};
    rd_pipe[0] <= (bus.mem_wmask_o != 4'h0) ? 32'h0 : ram[bus.mem_addr_o[7:2]];
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
    if (rst) begin
      for (int w = 0; w < 64; w++) ram[w] <= 32'h0;
      ram[0] <= 32'hAAAA0000;
      ram[1] <= 32'hBBBB0001;
      ram[2] <= 32'h11223344;
      ram[4] <= 32'h00500093;
    end else if (acc) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask_o[b]) ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wr_data_o[8*b +: 8];
    end
  end

  assign bus.mem_rd_valid_i = lat3 ? rv_pipe[2] : rv_pipe[0];
  assign bus.mem_rd_data_i  = lat3 ? rd_pipe[2] : rd_pipe[0];

  typedef struct {
    logic        iv;  logic [7:0]  ia;
    logic        dv;  logic [7:0]  da;  logic [31:0] dwd; logic [3:0] dm;
    logic        ir;  logic        dr;  logic        mv;
    logic [7:0]  maddr; logic [31:0] mwd; logic [3:0] mwm;
    logic        irv; logic [31:0] ird;
    logic        drv; logic [31:0] drd;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(
    input logic iv, input logic [7:0] ia, input logic dv, input logic [7:0] da,
    input logic [31:0] dwd, input logic [3:0] dm,
    input logic ir, input logic dr, input logic mv,
    input logic [7:0] maddr, input logic [31:0] mwd, input logic [3:0] mwm,
    input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dwd = dwd; v.dm = dm;
    v.ir = ir; v.dr = dr; v.mv = mv; v.maddr = maddr; v.mwd = mwd; v.mwm = mwm;
    v.irv = irv; v.ird = ird; v.drv = drv; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] ia, input logic dv, input logic [7:0] da,
                       input logic [31:0] wd, input logic [3:0] wm);
    bus.instr_valid_i  = iv;
    bus.instr_addr_i   = ia;
    bus.data_valid_i   = dv;
    bus.data_addr_i    = da;
    bus.data_wr_data_i = wd;
    bus.data_wmask_i   = wm;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic contend();
    drive(1'b1, 8'h00, 1'b1, 8'h04, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks handshakes and both response ports at the current negedge
  task automatic expect_cyc(input string tag, input logic ir, input logic dr, input logic mv,
                            input logic irv, input logic [31:0] ird,
                            input logic drv, input logic [31:0] drd);
    chk({tag, ".instr_ready"}, 32'(bus.instr_ready_o), 32'(ir));
    chk({tag, ".data_ready"},  32'(bus.data_ready_o),  32'(dr));
    chk({tag, ".mem_valid"},   32'(bus.mem_valid_o),   32'(mv));
    chk({tag, ".instr_rd_valid"}, 32'(bus.instr_rd_valid_o), 32'(irv));
    chk({tag, ".instr_rd_data"},  bus.instr_rd_data_o, ird);
    chk({tag, ".data_rd_valid"},  32'(bus.data_rd_valid_o),  32'(drv));
    chk({tag, ".data_rd_data"},   bus.data_rd_data_o,  drd);
  endtask

  // One reset cycle with both requesters asserting; everything must read zero
  task automatic do_reset(input string tag);
    rst = 1'b1;
    contend();
    @(negedge clk);
    expect_cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk({tag, ".mem_addr"},    32'(bus.mem_addr_o),  32'h0);
    chk({tag, ".mem_wr_data"}, bus.mem_wr_data_o,    32'h0);
    chk({tag, ".mem_wmask"},   32'(bus.mem_wmask_o), 32'h0);
    tick();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    lat3  = 1'b0;
    flush = 1'b1;
    rst   = 1'b1;
    bus.mem_ready_i = 1'b1;
    idle();

    //             iv  ia    dv  da    dwd           dm    ir  dr  mv  maddr mwd          mwm   irv ird           drv drd
    vecs[0]  = mk(1, 8'h10, 0, 8'h00, 32'h0,        4'h0, 1, 0, 1, 8'h10, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 8'h00, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 8'h00, 32'h0,        4'h0, 1, 32'h00500093, 0, 32'h0);
    vecs[2]  = mk(1, 8'h00, 1, 8'h04, 32'h0,        4'h0, 0, 1, 1, 8'h04, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    vecs[3]  = mk(1, 8'h00, 1, 8'h04, 32'h0,        4'h0, 1, 0, 1, 8'h00, 32'h0,        4'h0, 0, 32'h0,        1, 32'hBBBB0001);
    vecs[4]  = mk(1, 8'h00, 1, 8'h04, 32'h0,        4'h0, 0, 1, 1, 8'h04, 32'h0,        4'h0, 1, 32'hAAAA0000, 0, 32'h0);
    vecs[5]  = mk(1, 8'h00, 1, 8'h04, 32'h0,        4'h0, 1, 0, 1, 8'h00, 32'h0,        4'h0, 0, 32'h0,        1, 32'hBBBB0001);
    vecs[6]  = mk(0, 8'h00, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 8'h00, 32'h0,        4'h0, 1, 32'hAAAA0000, 0, 32'h0);
    vecs[7]  = mk(0, 8'h00, 1, 8'h08, 32'hDEADBEEF, 4'h3, 0, 1, 1, 8'h08, 32'hDEADBEEF, 4'h3, 0, 32'h0,        0, 32'h0);
    vecs[8]  = mk(0, 8'h00, 1, 8'h08, 32'h0,        4'h0, 0, 1, 1, 8'h08, 32'h0,        4'h0, 0, 32'h0,        1, 32'h0);
    vecs[9]  = mk(0, 8'h00, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 8'h00, 32'h0,        4'h0, 0, 32'h0,        1, 32'h1122BEEF);
    vecs[10] = mk(1, 8'h10, 0, 8'h00, 32'hFFFFFFFF, 4'hF, 1, 0, 1, 8'h10, 32'h0,        4'h0, 0, 32'h0,        0, 32'h0);
    vecs[11] = mk(0, 8'h00, 0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 8'h00, 32'h0,        4'h0, 1, 32'h00500093, 0, 32'h0);

    do_reset("reset0");
    flush = 1'b0;

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dwd, vecs[i].dm);
      @(negedge clk);
      expect_cyc(tag, vecs[i].ir, vecs[i].dr, vecs[i].mv, vecs[i].irv, vecs[i].ird, vecs[i].drv, vecs[i].drd);
      chk({tag, ".mem_addr"},    32'(bus.mem_addr_o),  32'(vecs[i].maddr));
      chk({tag, ".mem_wr_data"}, bus.mem_wr_data_o,    vecs[i].mwd);
      chk({tag, ".mem_wmask"},   32'(bus.mem_wmask_o), 32'(vecs[i].mwm));
      tick();
    end

    // Backpressure with a 3-cycle RAM
    idle();
    repeat (3) tick();
    lat3 = 1'b1;
    do_reset("reset1");
    contend(); @(negedge clk); expect_cyc("bp0", 0, 1, 1, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("bp1", 1, 0, 1, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("bp2_full", 0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("bp3_pop_grant", 0, 1, 1, 0, 32'h0, 1, 32'hBBBB0001); tick();
    contend(); @(negedge clk); expect_cyc("bp4", 1, 0, 1, 1, 32'hAAAA0000, 0, 32'h0); tick();
    idle();    @(negedge clk); expect_cyc("bp5", 0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle();    @(negedge clk); expect_cyc("bp6", 0, 0, 0, 0, 32'h0, 1, 32'hBBBB0001); tick();
    idle();    @(negedge clk); expect_cyc("bp7", 0, 0, 0, 1, 32'hAAAA0000, 0, 32'h0); tick();

    // Reset with two requests in flight; their responses must be dropped
    contend(); @(negedge clk); expect_cyc("rm0", 0, 1, 1, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("rm1", 1, 0, 1, 0, 32'h0, 0, 32'h0); tick();
    do_reset("rm2_reset");
    idle();    @(negedge clk); expect_cyc("rm3_orphan", 0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle();    @(negedge clk); expect_cyc("rm4_orphan", 0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("rm5_data_first", 0, 1, 1, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("rm6", 1, 0, 1, 0, 32'h0, 0, 32'h0); tick();
    contend(); @(negedge clk); expect_cyc("rm7_full", 0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    idle();    @(negedge clk); expect_cyc("rm8", 0, 0, 0, 0, 32'h0, 1, 32'hBBBB0001); tick();
    idle();    @(negedge clk); expect_cyc("rm9", 0, 0, 0, 1, 32'hAAAA0000, 0, 32'h0); tick();

    // Priority must hold across idle cycles
    repeat (3) tick();
    lat3 = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 8'h04, 32'h0, 4'h0);
    @(negedge clk); expect_cyc("ip0", 0, 1, 1, 0, 32'h0, 0, 32'h0); tick();
    for (int k = 0; k < 5; k++) begin
      idle();
      @(negedge clk);
      if (k == 0) expect_cyc("ip_idle_rsp", 0, 0, 0, 0, 32'h0, 1, 32'hBBBB0001);
      else        expect_cyc($sformatf("ip_idle%0d", k), 0, 0, 0, 0, 32'h0, 0, 32'h0);
      tick();
    end
    contend(); @(negedge clk);
    expect_cyc("ip6_instr_wins", 1, 0, 1, 0, 32'h0, 0, 32'h0);
    chk("ip6.mem_addr", 32'(bus.mem_addr_o), 32'h0);
    tick();
    idle(); @(negedge clk); expect_cyc("ip7", 0, 0, 0, 1, 32'hAAAA0000, 0, 32'h0); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
